icache_responder: RTL and testbench

- Instruction-cache side of the cache-to-fetch interface: answers instruction fetch requests from the fetch stage.
- Blocking, direct-mapped, read-only cache with word-serial line refill from a simple memory port.
- Sits between the fetch stage (initiator) and the memory/bus side; the fetch stage sees only request/response/busy.

---
 rtl/icache_responder.sv | 187 ++++++++++++++++++
 tb/tb_icache_responder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/icache_responder.sv
// ============================================================================
// icache_responder : blocking direct-mapped read-only instruction cache with
//                    word-serial line refill. Optional counters: ICACHE_PERF_EN
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_responder #(
  parameter int ADDR       = 32,
  parameter int INST       = 32,
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_req,
  input  logic [ADDR-1:0]   ic_addr,
  input  logic              ic_flush,
  output logic              ic_busy,
  output logic              ic_valid,
  output logic [INST-1:0]   ic_inst,
  output logic              mem_req,
  output logic [ADDR-1:0]   mem_addr,
  input  logic              mem_ack,
  input  logic [INST-1:0]   mem_rdata
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]       perf_hit_cnt,
  output logic [31:0]       perf_miss_cnt
`endif
);

  localparam int c_OFF_W   = $clog2(INST / 8);
  localparam int c_WSEL_W  = $clog2(LINE_WORDS);
  localparam int c_IDX_W   = $clog2(SETS);
  localparam int c_WADDR_W = ADDR - c_OFF_W;
  localparam int c_TAG_W   = c_WADDR_W - c_WSEL_W - c_IDX_W;
  localparam logic [c_WSEL_W-1:0] c_LAST = c_WSEL_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOOKUP  = 2'd1,
    S_REFILL  = 2'd2,
    S_RESPOND = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [c_WADDR_W-1:0]  r_word_addr;
  logic [c_WSEL_W-1:0]   r_cnt;
  logic [c_WSEL_W-1:0]   w_cnt_nxt;
  logic                  r_abort;
  logic                  w_abort_nxt;
  logic [SETS-1:0]       r_valid;
  logic [c_TAG_W-1:0]    r_tag  [SETS];
  logic [INST-1:0]       r_data [SETS][LINE_WORDS];

  logic [c_WSEL_W-1:0]   w_wsel;
  logic [c_IDX_W-1:0]    w_idx;
  logic [c_TAG_W-1:0]    w_tag;
  logic                  w_hit;
  logic                  w_busy;
  logic                  w_accept;
  logic                  w_data_we;
  logic                  w_set_valid;
  logic                  w_resp;
  logic [INST-1:0]       w_word;

  // Byte-offset bits never reach the cache; only word addresses are kept.
  wire w_unused = &{1'b0, ic_addr[c_OFF_W-1:0]};

  assign w_wsel = r_word_addr[c_WSEL_W-1:0];
  assign w_idx  = r_word_addr[c_WSEL_W +: c_IDX_W];
  assign w_tag  = r_word_addr[c_WADDR_W-1 -: c_TAG_W];
  assign w_hit  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_word = r_data[w_idx][w_wsel];

  assign w_busy   = (r_state == S_REFILL) || (r_state == S_RESPOND) ||
                    ((r_state == S_LOOKUP) && !w_hit);
  assign w_accept = ic_req && !w_busy && !ic_flush;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_abort_nxt = r_abort;
    w_data_we   = 1'b0;
    w_set_valid = 1'b0;
    w_resp      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (ic_flush) begin
          w_state_nxt = S_IDLE;
        end else if (w_hit) begin
          w_resp      = 1'b1;
          w_state_nxt = w_accept ? S_LOOKUP : S_IDLE;
        end else begin
          w_cnt_nxt   = '0;
          w_abort_nxt = 1'b0;
          w_state_nxt = S_REFILL;
        end
      end
      S_REFILL: begin
        if (ic_flush) w_abort_nxt = 1'b1;
        if (mem_ack) begin
          w_data_we = 1'b1;
          w_cnt_nxt = r_cnt + c_WSEL_W'(1);
          if (r_cnt == c_LAST) begin
            w_abort_nxt = 1'b0;
            // A flush seen earlier or on this very ack drops the new line.
            if (r_abort || ic_flush) begin
              w_state_nxt = S_IDLE;
            end else begin
              w_set_valid = 1'b1;
              w_state_nxt = S_RESPOND;
            end
          end
        end
      end
      S_RESPOND: begin
        w_resp      = !ic_flush;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_abort     <= 1'b0;
      r_word_addr <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_abort <= w_abort_nxt;
      if (w_accept) r_word_addr <= ic_addr[ADDR-1:c_OFF_W];
    end
  end

  // Flush has priority over a completing refill so the line stays invalid.
  always_ff @(posedge clk) begin
    if (reset || ic_flush) begin
      r_valid <= '0;
    end else if (w_set_valid) begin
      r_valid[w_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_set_valid) r_tag[w_idx] <= w_tag;
    if (w_data_we)   r_data[w_idx][r_cnt] <= mem_rdata;
  end

  assign ic_busy  = w_busy;
  assign ic_valid = w_resp;
  assign ic_inst  = w_resp ? w_word : '0;
  assign mem_req  = (r_state == S_REFILL);
  assign mem_addr = mem_req ? {r_word_addr[c_WADDR_W-1:c_WSEL_W], r_cnt, {c_OFF_W{1'b0}}}
                            : '0;

`ifdef ICACHE_PERF_EN
  logic w_hit_evt;
  logic w_miss_evt;

  assign w_hit_evt  = (r_state == S_LOOKUP) && !ic_flush && w_hit;
  assign w_miss_evt = (r_state == S_LOOKUP) && !ic_flush && !w_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_hit_cnt  <= '0;
      perf_miss_cnt <= '0;
    end else begin
      if (w_hit_evt && (perf_hit_cnt != 32'hFFFF_FFFF))
        perf_hit_cnt <= perf_hit_cnt + 32'd1;
      if (w_miss_evt && (perf_miss_cnt != 32'hFFFF_FFFF))
        perf_miss_cnt <= perf_miss_cnt + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_icache_responder.sv
// ============================================================================
// tb_icache_responder : directed scoreboard bench for icache_responder
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_icache_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        ic_req;
  logic [31:0] ic_addr;
  logic        ic_flush;
  logic        ic_busy;
  logic        ic_valid;
  logic [31:0] ic_inst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  icache_responder dut (
    .clk       (clk),
    .reset     (reset),
    .ic_req    (ic_req),
    .ic_addr   (ic_addr),
    .ic_flush  (ic_flush),
    .ic_busy   (ic_busy),
    .ic_valid  (ic_valid),
    .ic_inst   (ic_inst),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] maddr_q[$];
  int          stall_cfg  = 0;
  int          stall_left = 0;
  int          ack_count  = 0;
  bit          fill_pend  = 1'b0;
  bit          resp_after_fill = 1'b1;
  bit          valid_seen;
  bit          mreq_seen;
  int          ack_base;

  // Memory contents: line 0x1000 holds 0xA0.., line 0x1400 holds 0xB0..
  function automatic logic [31:0] mdata(input logic [31:0] a);
    logic [31:0] base;
    base = a[10] ? 32'hB0 : 32'hA0;
    return base + 32'(a[3:2]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: sample at negedge, answer memory, then step past posedge.
  task automatic cyc();
    logic [31:0] e;
    @(negedge clk);
    valid_seen = ic_valid;
    mreq_seen  = mem_req;
    if (fill_pend) begin
      chk("miss_latency", 32'(ic_valid), 32'(resp_after_fill));
      chk("busy_after_fill", 32'(ic_busy), 32'(resp_after_fill));
      fill_pend = 1'b0;
    end
    if (ic_valid) begin
      if (exp_q.size() == 0) chk("unexpected_valid", 32'(ic_valid), 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("ic_inst", ic_inst, e);
      end
    end else if (ic_inst !== 32'd0) begin
      chk("ic_inst_zero", ic_inst, 32'd0);
    end
    mem_ack = 1'b0;
    if (mem_req) begin
      chk("busy_in_refill", 32'(ic_busy), 32'd1);
      if (maddr_q.size() == 0) chk("unexpected_mem_req", 32'(mem_req), 32'd0);
      else begin
        chk("mem_addr", mem_addr, maddr_q[0]);
        if (stall_left > 0) stall_left--;
        else begin
          e = maddr_q.pop_front();
          mem_ack    = 1'b1;
          mem_rdata  = mdata(e);
          stall_left = stall_cfg;
          ack_count++;
          if (maddr_q.size() == 0) fill_pend = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [31:0] a, input bit miss, input bit resp);
    chk("busy_at_req", 32'(ic_busy), 32'd0);
    if (resp) exp_q.push_back(mdata(a));
    if (miss)
      for (int k = 0; k < 4; k++) maddr_q.push_back({a[31:4], 4'b0} + 32'(k * 4));
    ic_req  = 1'b1;
    ic_addr = a;
    cyc();
    ic_req  = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && maddr_q.size() == 0 && !fill_pend && !ic_busy) break;
      cyc();
    end
    chk("drain_pending", 32'(exp_q.size() + maddr_q.size()), 32'd0);
    chk("drain_busy", 32'(ic_busy), 32'd0);
  endtask

  initial begin
    reset = 1'b1; ic_req = 1'b0; ic_addr = '0; ic_flush = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(ic_busy), 32'd0);
    chk("rst_valid", 32'(ic_valid), 32'd0);
    chk("rst_inst", ic_inst, 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    reset = 1'b0;

    // Cold miss
    req(32'h0000_1008, 1'b1, 1'b1);
    drain(40);

    // Back-to-back hits
    req(32'h0000_1000, 1'b0, 1'b1);
    req(32'h0000_100C, 1'b0, 1'b1);
    chk("hit1_latency", 32'(valid_seen), 32'd1);
    chk("hit1_no_mem", 32'(mreq_seen), 32'd0);
    cyc();
    chk("hit2_latency", 32'(valid_seen), 32'd1);
    chk("hit2_no_mem", 32'(mreq_seen), 32'd0);
    drain(10);

    // Conflict eviction, then re-refill of the original line with ack stalls
    req(32'h0000_1408, 1'b1, 1'b1);
    drain(40);
    stall_cfg = 3;
    req(32'h0000_1008, 1'b1, 1'b1);
    drain(80);
    stall_cfg = 0;
    req(32'h0000_1008, 1'b0, 1'b1);
    cyc();
    chk("hit_after_stall", 32'(valid_seen), 32'd1);
    drain(10);

    // Flush on the second ack: refill completes but delivers nothing
    resp_after_fill = 1'b0;
    ack_base = ack_count;
    req(32'h0000_1408, 1'b1, 1'b0);
    cyc();
    cyc();
    ic_flush = 1'b1;
    cyc();
    ic_flush = 1'b0;
    drain(40);
    chk("flush_acks", 32'(ack_count - ack_base), 32'd4);
    resp_after_fill = 1'b1;
    req(32'h0000_1008, 1'b1, 1'b1);
    drain(40);

    // Reset after one ack
    req(32'h0000_1408, 1'b1, 1'b0);
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
    chk("rst_mid_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mid_busy", 32'(ic_busy), 32'd0);
    chk("rst_mid_valid", 32'(ic_valid), 32'd0);
    chk("rst_mid_mem_addr", mem_addr, 32'd0);
    reset = 1'b0;
    exp_q.delete();
    maddr_q.delete();
    stall_left = 0;
    fill_pend  = 1'b0;
    req(32'h0000_1008, 1'b1, 1'b1);
    drain(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
